multicycle_ctrl_fsm: RTL and testbench

Registered, parametrised successor to the controller next-state logic of the 16-bit multicycle core. It holds the controller state register and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for the 3-bit opcode set. Unlike the purely combinational next-state decode, it stalls on a memory ready handshake and holds a multi-cycle multiply for a parameterised latency. It also adds a memory-timeout error trap, a resumable HALT and an instruction-complete pulse. It sits between the instruction register and the datapath control-signal decoder, which consumes `state_o`.

---
 rtl/multicycle_ctrl_fsm.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - registered multicycle controller FSM with memory stalls, multiply latency and timeout trap
module multicycle_ctrl_fsm #(
    parameter int MULT_LAT    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] op_code,
    input  logic       beq_en,
    input  logic       mem_ready,
    input  logic       resume,
    output logic [3:0] state_o,
    output logic       mem_req,
    output logic       instr_done,
    output logic       halted,
    output logic       timeout_err
);

    localparam int MUL_W   = ($clog2(MULT_LAT + 1) < 1) ? 1 : $clog2(MULT_LAT + 1);
    localparam int STALL_W = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [MUL_W-1:0]   MUL_LOAD   = MUL_W'(MULT_LAT - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MEM_TIMEOUT - 1);
    localparam bit                 TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        ALU_EXEC  = 4'd6,
        ALU_WB    = 4'd7,
        SLT       = 4'd8,
        JUMP      = 4'd9,
        BEQ       = 4'd10,
        HALT      = 4'd11,
        ERROR     = 4'd12
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [3:0]           op_q;
    logic [MUL_W-1:0]     mul_cnt;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 stall_wait;
    logic                 timeout_hit;
    logic                 completes;
    logic                 enter_mem;

    always_comb begin
        state_n     = state;
        stall_wait  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            FETCH: begin
                if (mem_ready) state_n = DECODE;
                else           stall_wait = 1'b1;
            end
            DECODE: begin
                case (op_code)
                    3'b000:                 state_n = HALT;
                    3'b001, 3'b010, 3'b011: state_n = ALU_EXEC;
                    3'b100, 3'b101:         state_n = MEM_ADDR;
                    3'b110:                 state_n = SLT;
                    default:                state_n = beq_en ? BEQ : JUMP;
                endcase
            end
            MEM_ADDR: state_n = ((op_q == 4'b1010) || (op_q == 4'b1011)) ? MEM_WRITE : MEM_READ;
            MEM_READ: begin
                if (mem_ready) state_n = MEM_WB;
                else           stall_wait = 1'b1;
            end
            MEM_WRITE: begin
                if (mem_ready) state_n = FETCH;
                else           stall_wait = 1'b1;
            end
            ALU_EXEC: begin
                if (mul_cnt == '0) state_n = ALU_WB;
            end
            MEM_WB, ALU_WB, SLT, JUMP, BEQ: state_n = FETCH;
            HALT: begin
                if (resume) state_n = FETCH;
            end
            ERROR:   state_n = ERROR;
            default: state_n = ERROR;
        endcase

        // The limit cycle only traps when memory is still not ready.
        if (TIMEOUT_EN && stall_wait && (stall_cnt == STALL_LAST)) begin
            state_n     = ERROR;
            timeout_hit = 1'b1;
        end
    end

    always_comb begin
        completes = 1'b0;
        if (state_n == FETCH) begin
            case (state)
                MEM_WB, MEM_WRITE, ALU_WB, SLT, JUMP, BEQ: completes = 1'b1;
                default:                                   completes = 1'b0;
            endcase
        end
        enter_mem = (state_n != state) &&
                    ((state_n == FETCH) || (state_n == MEM_READ) || (state_n == MEM_WRITE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            op_q        <= '0;
            mul_cnt     <= '0;
            stall_cnt   <= '0;
            instr_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_n;
            instr_done <= completes;
            if (timeout_hit) timeout_err <= 1'b1;

            if (state == DECODE) op_q <= {op_code, beq_en};

            // Loaded on entry so ALU_EXEC lasts count+1 cycles.
            if ((state == DECODE) && (state_n == ALU_EXEC))
                mul_cnt <= (op_code == 3'b011) ? MUL_LOAD : '0;
            else if ((state == ALU_EXEC) && (mul_cnt != '0))
                mul_cnt <= mul_cnt - MUL_W'(1);

            if (enter_mem)
                stall_cnt <= '0;
            else if (stall_wait && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign state_o = state;
    assign mem_req = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized instruction-level bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    localparam int MULT_LAT    = 4;
    localparam int MEM_TIMEOUT = 15;

    localparam int unsigned S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                            S_MEM_WB = 4, S_MEM_WRITE = 5, S_ALU_EXEC = 6, S_ALU_WB = 7,
                            S_SLT = 8, S_JUMP = 9, S_BEQ = 10, S_HALT = 11, S_ERROR = 12;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic       beq_en = 1'b0;
    logic       mem_ready = 1'b0;
    logic       resume = 1'b0;
    logic [3:0] state_o;
    logic       mem_req;
    logic       instr_done;
    logic       halted;
    logic       timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .MULT_LAT    (MULT_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_code     (op_code),
        .beq_en      (beq_en),
        .mem_ready   (mem_ready),
        .resume      (resume),
        .state_o     (state_o),
        .mem_req     (mem_req),
        .instr_done  (instr_done),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle plan: expected state plus the inputs to present during that cycle.
    int unsigned q_state[$];
    bit          q_rdy[$];
    bit          q_res[$];
    bit          q_done[$];
    bit [3:0]    q_op[$];

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push(input int unsigned st, input bit rdy, input bit res, input bit done,
                        input bit [3:0] opb);
        q_state.push_back(st);
        q_rdy.push_back(rdy);
        q_res.push_back(res);
        q_done.push_back(done);
        q_op.push_back((st == S_DECODE) ? opb : 4'($urandom_range(0, 15)));
    endtask

    task automatic build_instr(input bit [2:0] op, input bit beq, input int sf, input int sm,
                               input int h, input bit done_first);
        for (int i = 0; i < sf; i++) push(S_FETCH, 1'b0, rnd_bit(), done_first && (i == 0), 4'd0);
        push(S_FETCH, 1'b1, rnd_bit(), done_first && (sf == 0), 4'd0);
        push(S_DECODE, rnd_bit(), rnd_bit(), 1'b0, {op, beq});
        case (op)
            3'd0: begin
                for (int i = 0; i < h; i++) push(S_HALT, rnd_bit(), 1'b0, 1'b0, 4'd0);
                push(S_HALT, rnd_bit(), 1'b1, 1'b0, 4'd0);
            end
            3'd1, 3'd2: begin
                push(S_ALU_EXEC, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
                push(S_ALU_WB, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
            end
            3'd3: begin
                for (int i = 0; i < MULT_LAT; i++) push(S_ALU_EXEC, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
                push(S_ALU_WB, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
            end
            3'd4: begin
                push(S_MEM_ADDR, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
                for (int i = 0; i < sm; i++) push(S_MEM_READ, 1'b0, rnd_bit(), 1'b0, 4'd0);
                push(S_MEM_READ, 1'b1, rnd_bit(), 1'b0, 4'd0);
                push(S_MEM_WB, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
            end
            3'd5: begin
                push(S_MEM_ADDR, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
                for (int i = 0; i < sm; i++) push(S_MEM_WRITE, 1'b0, rnd_bit(), 1'b0, 4'd0);
                push(S_MEM_WRITE, 1'b1, rnd_bit(), 1'b0, 4'd0);
            end
            3'd6:    push(S_SLT, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
            default: push(beq ? S_BEQ : S_JUMP, rnd_bit(), rnd_bit(), 1'b0, 4'd0);
        endcase
    endtask

    // Entered and left at a falling edge: check outputs, drive inputs, advance one cycle.
    task automatic run_plan();
        int unsigned st;
        bit          mreq;
        bit [3:0]    opb;
        while (q_state.size() > 0) begin
            st  = q_state.pop_front();
            opb = q_op.pop_front();
            mreq = (st == S_FETCH) || (st == S_MEM_READ) || (st == S_MEM_WRITE);
            check("state", 32'(state_o), st);
            check("mem_req", 32'(mem_req), 32'(mreq));
            check("instr_done", 32'(instr_done), 32'(q_done.pop_front()));
            check("halted", 32'(halted), 32'(st == S_HALT));
            check("timeout_err", 32'(timeout_err), 32'd0);
            mem_ready = q_rdy.pop_front();
            resume    = q_res.pop_front();
            op_code   = opb[3:1];
            beq_en    = opb[0];
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        resume    = 1'b0;
        #1;
        check("rst_state", 32'(state_o), S_FETCH);
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_done", 32'(instr_done), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit       prev_done;
        bit [2:0] op;

        @(negedge clk);
        do_reset();

        // Directed ADD: 0,1,6,7,0 with the completion pulse on the fifth cycle.
        build_instr(3'd1, 1'b0, 0, 0, 0, 1'b0);
        push(S_FETCH, 1'b0, 1'b0, 1'b1, 4'd0);
        run_plan();

        // Random instruction stream against the instruction-level model.
        do_reset();
        prev_done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            build_instr(op, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(1, 9), prev_done);
            run_plan();
            prev_done = (op != 3'd0);
        end
        push(S_FETCH, 1'b0, 1'b0, prev_done, 4'd0);
        run_plan();

        // Timeout: 15 stalled FETCH cycles trap into ERROR, which is sticky.
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT; i++) push(S_FETCH, 1'b0, 1'b0, 1'b0, 4'd0);
        run_plan();
        for (int i = 0; i < 4; i++) begin
            check("to_state", 32'(state_o), S_ERROR);
            check("to_err", 32'(timeout_err), 32'd1);
            check("to_mem_req", 32'(mem_req), 32'd0);
            mem_ready = 1'b1;
            resume    = 1'b1;
            @(negedge clk);
        end

        // Ready on the limit cycle wins over the timeout.
        do_reset();
        build_instr(3'd6, 1'b0, MEM_TIMEOUT - 1, 0, 0, 1'b0);
        push(S_FETCH, 1'b0, 1'b0, 1'b1, 4'd0);
        run_plan();

        // Reset during the second ALU_EXEC cycle of a multiply, then a clean ADD.
        do_reset();
        push(S_FETCH, 1'b1, 1'b0, 1'b0, 4'd0);
        push(S_DECODE, 1'b1, 1'b0, 1'b0, 4'b0110);
        push(S_ALU_EXEC, 1'b1, 1'b0, 1'b0, 4'd0);
        run_plan();
        check("mult_2nd_exec", 32'(state_o), S_ALU_EXEC);
        do_reset();
        build_instr(3'd1, 1'b0, 0, 0, 0, 1'b0);
        push(S_FETCH, 1'b0, 1'b0, 1'b1, 4'd0);
        run_plan();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
